// File: rtl/fixed_round_sat_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fixed_round_sat_pipe
// Purpose  : Two-stage handshaked fixed-point requantiser with per-beat
//            rounding mode, per-lane saturation and a sticky saturation count.
// Revision : 1.0 - initial release
// ============================================================================
module fixed_round_sat_pipe #(
    parameter int IN_SIZE        = 4,
    parameter int IN_WIDTH       = 16,
    parameter int IN_FRAC_WIDTH  = 8,
    parameter int OUT_WIDTH      = 8,
    parameter int OUT_FRAC_WIDTH = 4,
    parameter int SAT_CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [IN_SIZE*IN_WIDTH-1:0]    data_in,
    input  logic [1:0]                     round_mode,
    input  logic                           data_in_valid,
    output logic                           data_in_ready,
    output logic [IN_SIZE*OUT_WIDTH-1:0]   data_out,
    output logic [IN_SIZE-1:0]             data_out_sat,
    output logic                           data_out_valid,
    input  logic                           data_out_ready,
    input  logic                           sat_clear,
    output logic [SAT_CNT_WIDTH-1:0]       sat_count
);

    localparam int c_SHIFT = IN_FRAC_WIDTH - OUT_FRAC_WIDTH;
    // Wide enough that rounding up the largest quotient cannot wrap.
    localparam int c_MID_W = IN_WIDTH - c_SHIFT + 1;
    localparam int c_POP_W = $clog2(IN_SIZE + 1);
    localparam int c_SUM_W = SAT_CNT_WIDTH + 1;

    localparam logic [1:0] c_RND_FLOOR     = 2'd0;
    localparam logic [1:0] c_RND_HALF_UP   = 2'd1;
    localparam logic [1:0] c_RND_HALF_EVEN = 2'd2;
    localparam logic [1:0] c_RND_ZERO      = 2'd3;

    logic                          w_s1_en;
    logic                          w_s2_en;
    logic                          w_xfer;
    logic signed [c_MID_W-1:0]     w_round   [IN_SIZE];
    logic signed [c_MID_W-1:0]     r_s1_data [IN_SIZE];
    logic                          r_s1_valid;
    logic [IN_SIZE*OUT_WIDTH-1:0]  w_sat_val;
    logic [IN_SIZE-1:0]            w_sat_flag;
    logic [IN_SIZE*OUT_WIDTH-1:0]  r_out_data;
    logic [IN_SIZE-1:0]            r_out_sat;
    logic                          r_out_valid;
    logic [c_POP_W-1:0]            w_pop;
    logic [SAT_CNT_WIDTH-1:0]      w_cnt_base;
    logic [c_SUM_W-1:0]            w_cnt_sum;
    logic [SAT_CNT_WIDTH-1:0]      w_cnt_next;
    logic [SAT_CNT_WIDTH-1:0]      r_sat_count;

    assign w_s2_en        = !r_out_valid || data_out_ready;
    assign w_s1_en        = !r_s1_valid || w_s2_en;
    assign w_xfer         = r_out_valid && data_out_ready;
    assign data_in_ready  = w_s1_en;
    assign data_out       = r_out_data;
    assign data_out_sat   = r_out_sat;
    assign data_out_valid = r_out_valid;
    assign sat_count      = r_sat_count;

    for (genvar gi = 0; gi < IN_SIZE; gi++) begin : g_lane
        logic signed [IN_WIDTH-1:0] w_x;
        assign w_x = data_in[gi*IN_WIDTH +: IN_WIDTH];

        if (c_SHIFT > 0) begin : g_right
            localparam logic [IN_WIDTH-1:0] c_S_MASK = IN_WIDTH'((1 << (c_SHIFT - 1)) - 1);
            logic signed [c_MID_W-1:0] w_q;
            logic w_l, w_r, w_s, w_neg, w_inc;

            assign w_q   = c_MID_W'(w_x >>> c_SHIFT);
            assign w_l   = w_x[c_SHIFT];
            assign w_r   = w_x[c_SHIFT-1];
            assign w_s   = |(w_x & c_S_MASK);
            assign w_neg = w_x[IN_WIDTH-1];
            assign w_inc = (round_mode == c_RND_HALF_UP)   ? w_r :
                           (round_mode == c_RND_HALF_EVEN) ? (w_r & (w_s | w_l)) :
                           (round_mode == c_RND_ZERO)      ? (w_neg & (w_r | w_s)) :
                                                             1'b0;
            assign w_round[gi] = w_q + c_MID_W'(w_inc);
        end else if (c_SHIFT == 0) begin : g_pass
            assign w_round[gi] = c_MID_W'(w_x);
        end else begin : g_left
            localparam int c_LSH = -c_SHIFT;
            assign w_round[gi] = c_MID_W'(w_x) <<< c_LSH;
        end

        if (c_MID_W > OUT_WIDTH) begin : g_clamp
            localparam logic signed [c_MID_W-1:0] c_SAT_MAX = c_MID_W'((1 << (OUT_WIDTH - 1)) - 1);
            localparam logic signed [c_MID_W-1:0] c_SAT_MIN = ~c_SAT_MAX;
            logic w_hi, w_lo;

            assign w_hi = r_s1_data[gi] > c_SAT_MAX;
            assign w_lo = r_s1_data[gi] < c_SAT_MIN;
            assign w_sat_flag[gi] = w_hi || w_lo;
            assign w_sat_val[gi*OUT_WIDTH +: OUT_WIDTH] =
                w_hi ? OUT_WIDTH'(c_SAT_MAX) :
                w_lo ? OUT_WIDTH'(c_SAT_MIN) :
                       OUT_WIDTH'(r_s1_data[gi]);
        end else begin : g_fit
            assign w_sat_flag[gi] = 1'b0;
            assign w_sat_val[gi*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(r_s1_data[gi]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_valid <= data_in_valid;
        end
    end

    // Intermediate lanes carry no reset; the valid bit qualifies them.
    always_ff @(posedge clk) begin
        if (w_s1_en && data_in_valid) begin
            for (int i = 0; i < IN_SIZE; i++) begin
                r_s1_data[i] <= w_round[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= '0;
        end else if (w_s2_en) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_sat_val;
                r_out_sat  <= w_sat_flag;
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < IN_SIZE; i++) begin
            w_pop = w_pop + c_POP_W'(r_out_sat[i]);
        end
    end

    // Clear takes priority, then the transferring beat is added on top.
    always_comb begin
        w_cnt_base = sat_clear ? '0 : r_sat_count;
        w_cnt_sum  = {1'b0, w_cnt_base} + c_SUM_W'(w_pop);
        w_cnt_next = w_cnt_base;
        if (w_xfer) begin
            w_cnt_next = w_cnt_sum[SAT_CNT_WIDTH] ? '1 : w_cnt_sum[SAT_CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_count <= '0;
        end else begin
            r_sat_count <= w_cnt_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fixed_round_sat_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fixed_round_sat_pipe
// Purpose  : Directed self-checking bench for fixed_round_sat_pipe (defaults).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fixed_round_sat_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] data_in;
    logic [1:0]  round_mode;
    logic        data_in_valid;
    logic        data_in_ready;
    logic [31:0] data_out;
    logic [3:0]  data_out_sat;
    logic        data_out_valid;
    logic        data_out_ready;
    logic        sat_clear;
    logic [15:0] sat_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fixed_round_sat_pipe dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .round_mode     (round_mode),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_sat   (data_out_sat),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .sat_clear      (sat_clear),
        .sat_count      (sat_count)
    );

    function automatic logic [63:0] pk(input logic [15:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [31:0] pko(input logic [7:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Integer reference: value/16 rounded per mode, then clamped to int8.
    function automatic logic [8:0] ref_lane(input logic [15:0] x, input logic [1:0] m);
        int v, fl, fr, res;
        v  = int'($signed(x));
        fl = v >>> 4;
        fr = v & 15;
        case (m)
            2'd0:    res = fl;
            2'd1:    res = fl + ((fr >= 8) ? 1 : 0);
            2'd2:    res = fl + (((fr > 8) || (fr == 8 && (fl & 1) != 0)) ? 1 : 0);
            default: res = fl + ((v < 0 && fr != 0) ? 1 : 0);
        endcase
        if (res > 127)  return {1'b1, 8'h7F};
        if (res < -128) return {1'b1, 8'h80};
        return {1'b0, res[7:0]};
    endfunction

    function automatic logic [35:0] ref_beat(input logic [63:0] d, input logic [1:0] m);
        logic [31:0] o;
        logic [3:0]  s;
        logic [8:0]  r;
        for (int i = 0; i < 4; i++) begin
            r = ref_lane(d[i*16 +: 16], m);
            o[i*8 +: 8] = r[7:0];
            s[i] = r[8];
        end
        return {s, o};
    endfunction

    // Called at posedge+1 with an empty pipe; returns the output seen two edges later.
    task automatic drive_beat(input logic [63:0] d, input logic [1:0] m,
                              output logic v, output logic [31:0] o, output logic [3:0] s);
        data_out_ready = 1'b1;
        data_in        = d;
        round_mode     = m;
        data_in_valid  = 1'b1;
        @(posedge clk); #1;
        data_in_valid  = 1'b0;
        @(posedge clk); #1;
        v = data_out_valid;
        o = data_out;
        s = data_out_sat;
    endtask

    task automatic test_reset;
        rst = 1'b1; data_in = '0; round_mode = '0; data_in_valid = 1'b0;
        data_out_ready = 1'b1; sat_clear = 1'b0;
        #12;
        checks++;
        if (data_out_valid !== 1'b0 || data_out !== 32'h0 || data_out_sat !== 4'h0 || sat_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b o=%h s=%h c=%h want 0 0 0 0",
                     data_out_valid, data_out, data_out_sat, sat_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (data_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", data_in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rounding;
        logic [63:0] vec [2];
        logic [31:0] exp_o [2][4];
        logic        v;
        logic [31:0] o;
        logic [3:0]  s;
        vec[0] = pk(16'h0028, 16'h0038, 16'hFFD8, 16'h0000);
        vec[1] = pk(16'h0029, 16'hFFD7, 16'h0030, 16'hFFF0);
        exp_o[0][0] = pko(8'h02, 8'h03, 8'hFD, 8'h00);
        exp_o[0][1] = pko(8'h03, 8'h04, 8'hFE, 8'h00);
        exp_o[0][2] = pko(8'h02, 8'h04, 8'hFE, 8'h00);
        exp_o[0][3] = pko(8'h02, 8'h03, 8'hFE, 8'h00);
        exp_o[1][0] = pko(8'h02, 8'hFD, 8'h03, 8'hFF);
        exp_o[1][1] = pko(8'h03, 8'hFD, 8'h03, 8'hFF);
        exp_o[1][2] = pko(8'h03, 8'hFD, 8'h03, 8'hFF);
        exp_o[1][3] = pko(8'h02, 8'hFE, 8'h03, 8'hFF);
        for (int k = 0; k < 2; k++) begin
            for (int m = 0; m < 4; m++) begin
                drive_beat(vec[k], 2'(m), v, o, s);
                checks++;
                if (v !== 1'b1 || o !== exp_o[k][m] || s !== 4'h0) begin
                    errors++;
                    $display("FAIL round_v%0d_m%0d got v=%b o=%h s=%h want 1 %h 0",
                             k, m, v, o, s, exp_o[k][m]);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation;
        logic        v;
        logic [31:0] o;
        logic [3:0]  s;
        sat_clear = 1'b1;
        @(posedge clk); #1;
        sat_clear = 1'b0;
        checks++;
        if (sat_count !== 16'd0) begin
            errors++;
            $display("FAIL sat_clear_idle got %0d want 0", sat_count);
        end
        drive_beat(pk(16'h7FFF, 16'h8000, 16'h07F0, 16'hF800), 2'd1, v, o, s);
        checks++;
        if (v !== 1'b1 || o !== pko(8'h7F, 8'h80, 8'h7F, 8'h80) || s !== 4'b0011) begin
            errors++;
            $display("FAIL sat_bounds got v=%b o=%h s=%b want 1 80 7f 80 7f 0011", v, o, s);
        end
        @(posedge clk); #1;
        checks++;
        if (sat_count !== 16'd2) begin
            errors++;
            $display("FAIL sat_count_first got %0d want 2", sat_count);
        end
        // 127.5 rounds up into saturation; -128.5 rounds up to exactly -128.
        drive_beat(pk(16'h07F8, 16'hF7F8, 16'h07F7, 16'hF808), 2'd1, v, o, s);
        checks++;
        if (v !== 1'b1 || o !== pko(8'h7F, 8'h80, 8'h7F, 8'h81) || s !== 4'b0001) begin
            errors++;
            $display("FAIL sat_round_edge got v=%b o=%h s=%b want 1 81 7f 80 7f 0001", v, o, s);
        end
        @(posedge clk); #1;
        checks++;
        if (sat_count !== 16'd3) begin
            errors++;
            $display("FAIL sat_count_second got %0d want 3", sat_count);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_o;
        data_out_ready = 1'b1;
        round_mode     = 2'd0;
        data_in        = {4{16'h0010}};
        data_in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i >= 1) begin
                exp_o = {4{8'(i)}};
                checks++;
                if (data_out_valid !== 1'b1 || data_out !== exp_o) begin
                    errors++;
                    $display("FAIL b2b_beat%0d got v=%b o=%h want 1 %h", i - 1, data_out_valid, data_out, exp_o);
                end
            end
            if (i < 3) data_in = {4{16'(16 * (i + 2))}};
            else       data_in_valid = 1'b0;
        end
        @(posedge clk); #1;
        checks++;
        if (data_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got %b want 0", data_out_valid);
        end
    endtask

    task automatic test_stream;
        logic [31:0] q_o [$];
        logic [3:0]  q_s [$];
        logic [31:0] prev_o, eo;
        logic [3:0]  prev_s, es;
        logic [35:0] r;
        logic        prev_stall, in_fire;
        int          sent, recv, cycles;
        sent = 0; recv = 0; cycles = 0; prev_stall = 1'b0;
        prev_o = '0; prev_s = '0;
        data_in_valid = 1'b0;
        while (recv < 200 && cycles < 5000) begin
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (data_out_valid !== 1'b1 || data_out !== prev_o || data_out_sat !== prev_s) begin
                    errors++;
                    $display("FAIL stall_hold got v=%b o=%h s=%h want 1 %h %h",
                             data_out_valid, data_out, data_out_sat, prev_o, prev_s);
                end
            end
            if (data_out_valid && data_out_ready) begin
                checks++;
                if (q_o.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra got o=%h want no beat", data_out);
                end else begin
                    eo = q_o.pop_front();
                    es = q_s.pop_front();
                    if (data_out !== eo || data_out_sat !== es) begin
                        errors++;
                        $display("FAIL stream_beat%0d got o=%h s=%h want %h %h", recv, data_out, data_out_sat, eo, es);
                    end
                end
                recv++;
            end
            in_fire = data_in_valid && data_in_ready;
            if (in_fire) begin
                r = ref_beat(data_in, round_mode);
                q_o.push_back(r[31:0]);
                q_s.push_back(r[35:32]);
                sent++;
            end
            prev_stall = data_out_valid && !data_out_ready;
            prev_o = data_out;
            prev_s = data_out_sat;
            @(posedge clk); #1;
            cycles++;
            if (in_fire || !data_in_valid) begin
                if (sent < 200) begin
                    data_in_valid = 1'b1;
                    round_mode    = 2'($urandom_range(0, 3));
                    for (int i = 0; i < 4; i++) begin
                        if ($urandom_range(0, 3) == 0) data_in[i*16 +: 16] = 16'($urandom);
                        else                           data_in[i*16 +: 16] = 16'($urandom_range(0, 4200) - 2100);
                    end
                end else begin
                    data_in_valid = 1'b0;
                end
            end
            data_out_ready = 1'($urandom_range(0, 1));
        end
        checks++;
        if (recv != 200 || q_o.size() != 0) begin
            errors++;
            $display("FAIL stream_count got %0d beats left %0d want 200 left 0", recv, q_o.size());
        end
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_sat_counter;
        logic        v;
        logic [31:0] o;
        logic [3:0]  s;
        sat_clear = 1'b1;
        @(posedge clk); #1;
        sat_clear = 1'b0;
        data_out_ready = 1'b1;
        round_mode     = 2'd0;
        data_in        = {4{16'h7FFF}};
        data_in_valid  = 1'b1;
        repeat (16383) begin
            @(posedge clk); #1;
        end
        data_in = pk(16'h7FFF, 16'h8000, 16'h0000, 16'h0000);
        @(posedge clk); #1;
        data_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sat_count !== 16'hFFFE) begin
            errors++;
            $display("FAIL cnt_preload got %h want fffe", sat_count);
        end
        drive_beat({4{16'h8000}}, 2'd0, v, o, s);
        @(posedge clk); #1;
        checks++;
        if (sat_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_clamp got %h want ffff", sat_count);
        end
        drive_beat({4{16'h7FFF}}, 2'd0, v, o, s);
        @(posedge clk); #1;
        checks++;
        if (sat_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_clamp_hold got %h want ffff", sat_count);
        end
        drive_beat(pk(16'h7FFF, 16'h0010, 16'h8000, 16'h0020), 2'd0, v, o, s);
        sat_clear = 1'b1;
        @(posedge clk); #1;
        sat_clear = 1'b0;
        checks++;
        if (sat_count !== 16'd2) begin
            errors++;
            $display("FAIL cnt_clear_xfer got %0d want 2", sat_count);
        end
    endtask

    task automatic test_reset_midflight;
        logic        v;
        logic [31:0] o;
        logic [3:0]  s;
        data_out_ready = 1'b0;
        round_mode     = 2'd0;
        data_in        = {4{16'h0100}};
        data_in_valid  = 1'b1;
        @(posedge clk); #1;
        data_in = {4{16'h0200}};
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (data_out_valid !== 1'b1 || data_in_ready !== 1'b0 || data_out !== {4{8'h10}}) begin
            errors++;
            $display("FAIL full_stall got v=%b rdy=%b o=%h want 1 0 10101010", data_out_valid, data_in_ready, data_out);
        end
        data_in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (data_out_valid !== 1'b0 || data_out !== 32'h0 || data_out_sat !== 4'h0 || sat_count !== 16'h0) begin
            errors++;
            $display("FAIL async_reset got v=%b o=%h s=%h c=%h want 0 0 0 0",
                     data_out_valid, data_out, data_out_sat, sat_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        data_out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (data_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush got %b want 0", data_out_valid);
        end
        drive_beat({4{16'h0028}}, 2'd1, v, o, s);
        checks++;
        if (v !== 1'b1 || o !== {4{8'h03}} || s !== 4'h0) begin
            errors++;
            $display("FAIL post_reset_beat got v=%b o=%h s=%h want 1 03030303 0", v, o, s);
        end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_stream();
        test_sat_counter();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fixed_round_sat_pipe.md
# fixed_round_sat_pipe

Pipelined, handshaked fixed-point requantiser. It converts IN_SIZE parallel signed lanes from one fixed-point format to another using a per-beat selectable rounding mode, then saturates each lane and flags any lane that saturated. A sticky saturation counter accumulates flagged lanes for debug. It sits between any arithmetic core and a narrower downstream consumer wherever a dataflow stream changes precision.

## Interface

Parameters:

- IN_SIZE, 4, lane count.
- IN_WIDTH, 16, input lane width (signed two's complement).
- IN_FRAC_WIDTH, 8, input fractional bits.
- OUT_WIDTH, 8, output lane width (signed).
- OUT_FRAC_WIDTH, 4, output fractional bits.
- SAT_CNT_WIDTH, 16, saturation counter width.

Ports:

- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  IN_WIDTH x [IN_SIZE]  input lanes.
- round_mode  in  2  rounding mode, sampled with each accepted beat.
- data_in_valid  in  1  input beat valid.
- data_in_ready  out  1  input beat accepted when valid & ready.
- data_out  out  OUT_WIDTH x [IN_SIZE]  output lanes.
- data_out_sat  out  IN_SIZE  per-lane saturation flag, aligned with data_out.
- data_out_valid  out  1  output beat valid.
- data_out_ready  in  1  downstream ready.
- sat_clear  in  1  synchronous clear of sat_count.
- sat_count  out  SAT_CNT_WIDTH  saturating count of saturated lanes transferred at the output.

## Operation

- Define SHIFT = IN_FRAC_WIDTH - OUT_FRAC_WIDTH.
  - SHIFT > 0: right shift with rounding.
  - SHIFT = 0: pass through; no rounding.
  - SHIFT < 0: left shift by -SHIFT with zero fill; no rounding.
- For SHIFT > 0, per lane:
  - q = arithmetic shift right of data_in by SHIFT.
  - l = bit[SHIFT] of the input.
  - r = bit[SHIFT-1] of the input.
  - s = OR of bits[SHIFT-2:0] (0 if SHIFT = 1).
  - neg = sign bit.
- Rounding modes; result = q + inc:
  - 0, floor: inc = 0.
  - 1, round-half-up (ties toward +inf): inc = r.
  - 2, round-half-even: inc = r & (s | l).
  - 3, toward zero: inc = neg & (r | s).
- Intermediate width: IN_WIDTH - SHIFT + 1 (or IN_WIDTH - SHIFT + 1 for the left-shift case). No wrap is permitted before saturation.
- Saturation range is [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Out-of-range values clamp to the nearest bound and set that lane's data_out_sat bit.
  - In-range values are truncated to OUT_WIDTH with the flag at 0.
- Pipeline:
  - Stage 1 registers the rounded intermediate lanes and a valid bit.
  - Stage 2 registers the saturated lanes, sat flags and data_out_valid.
- sat_count:
  - On each output transfer (data_out_valid & data_out_ready), add popcount(data_out_sat).
  - The count clamps at all-ones.
  - sat_clear = 1: the count is set to 0. If a transfer occurs in the same cycle, it is set to that beat's popcount instead (clear first, then add).

## Timing

- Reset values:
  - Stage valid bits, data_out_valid: 0.
  - data_out: all lanes 0.
  - data_out_sat: 0.
  - sat_count: 0.
  - data_in_ready: 1 once rst deasserts, since both stages are empty.
- Latency: a beat accepted at edge N appears on data_out after edge N+2 when there is no stall. Throughput is one beat per cycle.
- Stage advance: s2_en = !data_out_valid | data_out_ready; s1_en = !s1_valid | s2_en. data_in_ready = s1_en, which is combinational from data_out_ready.
- Stall hold: while data_out_valid & !data_out_ready, data_out, data_out_sat and data_out_valid hold stable. Stage 1 holds if it is full. No beat is lost or duplicated.
- Bubbles collapse: an empty stage accepts data even while downstream stalls.
- round_mode is captured only on an accepted beat. Mode changes between beats take effect per beat, with no pipeline flush.
- Reset asserted mid-operation: in-flight beats are discarded and all outputs return to reset values asynchronously.
- Data registers need no reset for correctness, but data_out is reset to 0 as specified.

## Test plan

All scenarios use the defaults, so SHIFT = 4.

- Lane value 0x0028 (2.5 LSB) with modes 0/1/2/3 → data_out 2/3/2/2; sat 0. Value 0x0038 (3.5 LSB) in mode 2 → 4.
- Lane value 0xFFD8 (-2.5 LSB) with modes 0/1/2/3 → -3/-2/-2/-2, i.e. 0xFD/0xFE/0xFE/0xFE.
- Lanes {0x7FFF, 0x8000, 0x07F0, 0xF800} in mode 1:
  - data_out → {0x7F, 0x80, 0x7F, 0x80}.
  - data_out_sat → 4'b0011.
  - sat_count 0 → 2 after transfer.
- Streaming with random data_out_ready (about 50%), 200 beats: the output sequence equals the reference model in order, with no drops or duplicates. data_out stays stable during every stall. Continuous ready gives 1 beat/cycle and latency 2.
- Saturation counter:
  - Preload sat_count to all-ones minus 1, then transfer a beat with 4 saturated lanes → all-ones.
  - Assert sat_clear in the same cycle as a transfer with 2 saturated lanes → 2.
- Assert rst with both stages full and data_out_ready = 0:
  - Outputs go to 0 and data_out_valid to 0 without waiting for a clock edge.
  - After release, the first new beat emerges 2 cycles after acceptance.
